// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable / reset sequencer.
// The sequencer states, the run-mode codes and a mode-validity helper.
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    function automatic logic mode_valid(input logic [1:0] mode);
        return mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_div_tick.sv
// Divider counter for the CPU clock-enable: counts while enabled, restarts on clear,
// and flags the clock where the count reaches the latched divider value.
module cpu_clk_ctrl_div_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 match
);

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;

    assign match = (div_cnt_q == div);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = match ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable and reset sequencer for the single-cycle CPU: holds the core in reset,
// then issues divided ce pulses in free-run, single-step or burst mode.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int BURST_WIDTH = 16,
    parameter int CYC_WIDTH   = 32,
    parameter int RST_CYCLES  = 4
) (
    input  logic                   inp_clk,
    input  logic                   inp_rst,
    input  logic [DIV_WIDTH-1:0]   inp_div,
    input  logic [1:0]             inp_mode,
    input  logic                   inp_go,
    input  logic [BURST_WIDTH-1:0] inp_burst_len,
    input  logic                   inp_halt,
    input  logic                   inp_soft_rst,
    output logic                   out_cpu_rst,
    output logic                   out_ce,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [CYC_WIDTH-1:0]   out_cycles
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [CYC_WIDTH-1:0]   cycles_q, cycles_d;
    logic                   cpu_rst_q, busy_q, done_q;

    logic go_ok;
    logic div_match;
    logic burst_zero;
    logic burst_last;

    assign go_ok      = (state_q == ST_IDLE) && inp_go && mode_valid(inp_mode);
    assign burst_zero = (mode_q == MODE_BURST) && (burst_q == '0);
    assign burst_last = ((burst_cnt_q + 1'b1) == burst_q);

    // A zero-length burst must never tick, even with a divide-by-one setting.
    assign out_ce = (state_q == ST_ACTIVE) && div_match && !inp_halt && !burst_zero;

    cpu_clk_ctrl_div_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div_tick (
        .clk   (inp_clk),
        .rst   (inp_rst),
        .clr   (go_ok),
        .en    (state_q == ST_ACTIVE),
        .div   (div_q),
        .match (div_match)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rst_cnt_d   = rst_cnt_q;
        div_d       = div_q;
        burst_d     = burst_q;
        burst_cnt_d = burst_cnt_q;
        cycles_d    = out_ce ? cycles_q + 1'b1 : cycles_q;

        case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (go_ok) begin
                    state_d     = ST_ACTIVE;
                    mode_d      = mode_e'(inp_mode);
                    div_d       = inp_div;
                    burst_d     = inp_burst_len;
                    burst_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (inp_halt || burst_zero) begin
                    state_d = ST_FINISH;
                end else if (out_ce) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (mode_q == MODE_STEP || (mode_q == MODE_BURST && burst_last)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Soft reset overrides go and halt and abandons the run without a done pulse.
        if (state_q != ST_RESET && inp_soft_rst) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
        end
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state_q     <= ST_RESET;
            mode_q      <= MODE_RUN;
            rst_cnt_q   <= '0;
            div_q       <= '0;
            burst_q     <= '0;
            burst_cnt_q <= '0;
            cycles_q    <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rst_cnt_q   <= rst_cnt_d;
            div_q       <= div_d;
            burst_q     <= burst_d;
            burst_cnt_q <= burst_cnt_d;
            cycles_q    <= cycles_d;
            cpu_rst_q   <= (state_d == ST_RESET);
            busy_q      <= (state_d == ST_ACTIVE);
            done_q      <= (state_d == ST_FINISH);
        end
    end

    assign out_cpu_rst = cpu_rst_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;
    assign out_cycles  = cycles_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus random traffic, every cycle compared
// against a cycle-level behavioural model of the sequencer.
module tb_cpu_clk_ctrl;

    localparam int DIV_W   = 8;
    localparam int BURST_W = 16;
    localparam int CYC_W   = 8;
    localparam int RST_CYC = 4;

    logic               inp_clk = 1'b0;
    logic               inp_rst = 1'b1;
    logic [DIV_W-1:0]   inp_div = '0;
    logic [1:0]         inp_mode = 2'b00;
    logic               inp_go = 1'b0;
    logic [BURST_W-1:0] inp_burst_len = '0;
    logic               inp_halt = 1'b0;
    logic               inp_soft_rst = 1'b0;
    logic               out_cpu_rst;
    logic               out_ce;
    logic               out_busy;
    logic               out_done;
    logic [CYC_W-1:0]   out_cycles;

    always #5 inp_clk = ~inp_clk;

    cpu_clk_ctrl #(
        .DIV_WIDTH   (DIV_W),
        .BURST_WIDTH (BURST_W),
        .CYC_WIDTH   (CYC_W),
        .RST_CYCLES  (RST_CYC)
    ) dut (
        .inp_clk       (inp_clk),
        .inp_rst       (inp_rst),
        .inp_div       (inp_div),
        .inp_mode      (inp_mode),
        .inp_go        (inp_go),
        .inp_burst_len (inp_burst_len),
        .inp_halt      (inp_halt),
        .inp_soft_rst  (inp_soft_rst),
        .out_cpu_rst   (out_cpu_rst),
        .out_ce        (out_ce),
        .out_busy      (out_busy),
        .out_done      (out_done),
        .out_cycles    (out_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = core in reset, 1 = waiting, 2 = ticking, 3 = done pulse.
    int m_phase = 0;
    int m_rst_edges = 0;
    int m_since_go = 0;
    int m_div = 0;
    int m_mode = 0;
    int m_len = 0;
    int m_ticks = 0;
    logic [CYC_W-1:0] m_cycles = '0;

    int n_ce = 0, n_done = 0, n_rst = 0, n_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_ce();
        if (m_phase != 2 || inp_halt) return 1'b0;
        if (m_mode == 2 && m_len == 0) return 1'b0;
        return (m_since_go % (m_div + 1)) == m_div;
    endfunction

    task automatic check_outs(input logic ce);
        chk("ce",      32'(out_ce),      32'(ce));
        chk("busy",    32'(out_busy),    32'(m_phase == 2));
        chk("done",    32'(out_done),    32'(m_phase == 3));
        chk("cpu_rst", 32'(out_cpu_rst), 32'(m_phase == 0));
        chk("cycles",  32'(out_cycles),  32'(m_cycles));
        n_ce   += int'(out_ce);
        n_done += int'(out_done);
        n_rst  += int'(out_cpu_rst);
        n_busy += int'(out_busy);
    endtask

    task automatic model_edge(input logic ce);
        if (ce) m_cycles = m_cycles + 1'b1;
        if (m_phase != 0 && inp_soft_rst) begin
            m_phase = 0;
            m_rst_edges = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_rst_edges++;
                    if (m_rst_edges == RST_CYC) m_phase = 1;
                end
                1: if (inp_go && inp_mode != 2'b11) begin
                    m_phase = 2;
                    m_div = int'(inp_div);
                    m_mode = int'(inp_mode);
                    m_len = int'(inp_burst_len);
                    m_since_go = 0;
                    m_ticks = 0;
                end
                2: begin
                    if (inp_halt) m_phase = 3;
                    else if (ce) begin
                        m_ticks++;
                        if (m_mode == 1 || (m_mode == 2 && m_ticks == m_len)) m_phase = 3;
                    end else if (m_mode == 2 && m_len == 0) m_phase = 3;
                    m_since_go++;
                end
                default: m_phase = 1;
            endcase
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic clk_cycle(input logic go, input logic halt, input logic srst);
        logic ce;
        inp_go = go;
        inp_halt = halt;
        inp_soft_rst = srst;
        #1;
        ce = model_ce();
        check_outs(ce);
        @(posedge inp_clk);
        model_edge(ce);
        @(negedge inp_clk);
    endtask

    task automatic do_reset();
        inp_rst = 1'b1;
        inp_go = 1'b0;
        inp_halt = 1'b0;
        inp_soft_rst = 1'b0;
        #1;
        m_phase = 0;
        m_rst_edges = 0;
        m_cycles = '0;
        check_outs(1'b0);
        repeat (2) @(posedge inp_clk);
        @(negedge inp_clk);
        inp_rst = 1'b0;
    endtask

    task automatic clear_counts();
        n_ce = 0; n_done = 0; n_rst = 0; n_busy = 0;
    endtask

    task automatic setup(input logic [1:0] mode, input int div, input int len);
        inp_mode = mode;
        inp_div = DIV_W'(div);
        inp_burst_len = BURST_W'(len);
    endtask

    initial begin
        @(negedge inp_clk);
        do_reset();

        // reset release
        clear_counts();
        repeat (6) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("rst_hold_len", 32'(n_rst), 32'(RST_CYC));
        chk("rst_no_ce", 32'(n_ce), 0);

        // RUN div=0, halt after 10 clocks
        setup(2'b00, 0, 0);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (10) clk_cycle(1'b0, 1'b0, 1'b0);
        clk_cycle(1'b0, 1'b1, 1'b0);
        repeat (3) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("run_ce", 32'(n_ce), 10);
        chk("run_done", 32'(n_done), 1);
        chk("run_cycles", 32'(out_cycles), 10);

        // BURST div=2 len=5
        setup(2'b10, 2, 5);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (20) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("burst_ce", 32'(n_ce), 5);
        chk("burst_done", 32'(n_done), 1);
        chk("burst_cycles", 32'(out_cycles), 15);

        // STEP div=3 with go held high: one ce per accepted go, 6 clocks each
        setup(2'b01, 3, 0);
        clear_counts();
        repeat (24) clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (4) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("step_ce", 32'(n_ce), 4);
        chk("step_done", 32'(n_done), 4);

        // BURST len=0: done without ce
        setup(2'b10, 2, 0);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (4) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("burst0_ce", 32'(n_ce), 0);
        chk("burst0_done", 32'(n_done), 1);

        // halt coincident with the second tick of a len=8 burst
        setup(2'b10, 1, 8);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (3) clk_cycle(1'b0, 1'b0, 1'b0);
        clk_cycle(1'b0, 1'b1, 1'b0);
        repeat (3) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("halt_ce", 32'(n_ce), 1);
        chk("halt_done", 32'(n_done), 1);
        chk("halt_cycles", 32'(out_cycles), 20);

        // soft reset mid-burst
        setup(2'b10, 0, 10);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (3) clk_cycle(1'b0, 1'b0, 1'b0);
        clk_cycle(1'b0, 1'b0, 1'b1);
        repeat (8) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("srst_ce", 32'(n_ce), 4);
        chk("srst_done", 32'(n_done), 0);
        chk("srst_rst_len", 32'(n_rst), 32'(RST_CYC));
        chk("srst_cycles", 32'(out_cycles), 24);

        // reserved mode is ignored
        setup(2'b11, 0, 3);
        clear_counts();
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (3) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("rsvd_busy", 32'(n_busy), 0);

        // async reset mid-RUN
        setup(2'b00, 0, 0);
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (5) clk_cycle(1'b0, 1'b0, 1'b0);
        do_reset();
        chk("arst_ce", 32'(out_ce), 0);
        chk("arst_cycles", 32'(out_cycles), 0);
        repeat (6) clk_cycle(1'b0, 1'b0, 1'b0);

        // long RUN to wrap the cycle counter (300 mod 256)
        setup(2'b00, 0, 0);
        clk_cycle(1'b1, 1'b0, 1'b0);
        repeat (300) clk_cycle(1'b0, 1'b0, 1'b0);
        clk_cycle(1'b0, 1'b1, 1'b0);
        repeat (2) clk_cycle(1'b0, 1'b0, 1'b0);
        chk("wrap_cycles", 32'(out_cycles), 44);

        // random traffic, inputs also wiggle while active
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                inp_mode = 2'($urandom_range(0, 3));
                inp_div = DIV_W'($urandom_range(0, 3));
                inp_burst_len = BURST_W'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                clk_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 59) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
